multi_ch_period_meter: RTL and testbench
========================================

Name: multi_ch_period_meter

Overview:
Multi-channel successor to the single-channel phase period detector, for the 8-channel board. Each channel debounces its phase input and measures the clk-cycle period between consecutive filtered rising edges, reporting a timeout result if no edge arrives. Per-channel results queue in one-deep holding slots. A round-robin serializer drains those slots onto a single valid/ready result stream toward the host/packet logic.

Parameters:
NUM_CH, 8, number of phase input channels (≥1)
CNT_W, 32, period counter and result width
FILT_LEN, 100, consecutive samples a new input level must persist before the filtered level changes (≥1)
TIMEOUT, 400000000, period count at which measurement aborts; must fit in CNT_W
CH_W (localparam), max(1, clog2(NUM_CH)), channel index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  global measurement enable
phase_in  in  NUM_CH  asynchronous phase inputs, bit i = channel i
ch_active  out  NUM_CH  bit i high while channel i is in MEAS
out_valid  out  1  result available
out_ready  in  1  consumer accepts result when out_valid & out_ready
out_ch  out  CH_W  channel index of result
out_period  out  CNT_W  measured period in clk cycles; 0 on timeout
out_timeout  out  1  result is a timeout
out_overrun  out  1  at least one earlier result on this channel was overwritten before being sent

Behaviour:
- Reset: all filtered levels 0, filter counters 0, FSMs IDLE, counters 0, slots empty, RR pointer 0, every output 0. Reset mid-operation discards all pending results and any held output (out_valid drops the next cycle).
- Input path per channel: 2-FF synchroniser, then debounce.
  - Filter counter counts cycles where the synced input ≠ filtered level; it clears on any match.
  - Filtered level flips when the count reaches FILT_LEN.
  - edge = filtered 0→1, registered: a one-cycle pulse.
- Channel FSM, states IDLE and MEAS:
  - IDLE: cnt held 0. Edge & en → MEAS.
  - MEAS: cnt <= cnt+1 each cycle.
    - Edge: capture period = cnt+1, cnt <= 0, stay MEAS. Edges at cycles t0 and t1 therefore give t1−t0.
    - Else if cnt+1 == TIMEOUT: capture period 0 with timeout=1, go IDLE. The next edge restarts measurement and is not itself a result.
  - en low: all channels go IDLE the next cycle; no capture that cycle; slots and output are unaffected.
- Slot per channel holds {pending, period, timeout, overrun}.
  - Capture while not pending: load the result, pending=1, overrun=0.
  - Capture while pending: overwrite period/timeout, set overrun=1.
  - Capture in the same cycle the slot is drained: the drained value goes out, and the slot reloads the new result with pending=1, overrun=0.
- Serializer:
  - Output register loads when (!out_valid | out_ready).
  - Source = the first pending slot searching from RR pointer+1 (mod NUM_CH) upward.
  - On load: the slot clears; RR pointer = granted channel.
  - No pending slot → out_valid=0.
  - Output fields stay stable while out_valid & !out_ready.
- Latency: edge pulse at cycle N → slot pending N+1 → out_valid earliest N+2. Back-to-back accepts sustain one result per cycle.
- Width: cnt saturation is unreachable because TIMEOUT ≤ 2^CNT_W−1. Channels are fully independent; simultaneous edges on all channels are all captured.

Test Plan:
Bench uses NUM_CH=4, FILT_LEN=4, TIMEOUT=1000.
- Ch0 clean square wave, high/low 100 cycles each, out_ready=1 → first edge gives no result; then repeated results ch=0, period=200, timeout=0, overrun=0.
- Ch1 high pulses of 3 cycles (glitches) superimposed on a 300-cycle period → glitches are ignored; period=300 reported only.
- Ch2: one edge, then input held low → after 1000 cycles, result ch=2, period=0, timeout=1; ch_active[2] drops; the next two edges 500 apart produce period=500.
- All 4 channels with identical 50-cycle periods, edges aligned, out_ready=1 → per round, four results in consecutive cycles, ch order rotating from RR pointer+1, each period=50.
- out_ready=0 for 120 cycles on ch3 with 50-cycle period → out fields stable while stalled; the first result after release has overrun=1 and period=50.
- Assert rst with out_valid=1 and slots pending → next cycle out_valid=0; no stale result appears after release.

Source files
------------

// File: rtl/multi_ch_period_meter.sv
// Debounced per-channel period measurement with one-deep result slots and a
// round-robin serializer feeding a single valid/ready result stream.

module period_meter_ch #(
   parameter int CNT_W    = 32,
   parameter int FILT_LEN = 100,
   parameter int TIMEOUT  = 400000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             phase,
   output logic             active,
   output logic             cap,
   output logic [CNT_W-1:0] cap_period,
   output logic             cap_timeout
);

   localparam int FW = $clog2(FILT_LEN + 1);

   typedef enum logic {IDLE, MEAS} state_t;

   logic             sync_a;
   logic             sync_b;
   logic             filt;
   logic             edge_p;
   logic [FW-1:0]    fcnt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             hit_to;
   state_t           state;
   state_t           state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= phase;
         sync_b <= sync_a;
      end
   end

   // The level only moves after FILT_LEN consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt   <= 1'b0;
         fcnt   <= '0;
         edge_p <= 1'b0;
      end else begin
         edge_p <= 1'b0;
         if (sync_b == filt) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILT_LEN - 1)) begin
            fcnt   <= '0;
            filt   <= sync_b;
            edge_p <= sync_b;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   assign cnt_inc = cnt + CNT_W'(1);
   assign hit_to  = (cnt_inc == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (edge_p) state_nxt = MEAS;
            MEAS:    if (!edge_p && hit_to) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      active      = (state == MEAS);
      cap         = en && (state == MEAS) && (edge_p || hit_to);
      cap_period  = edge_p ? cnt_inc : '0;
      cap_timeout = !edge_p;
   end

   // Counter restarts on every edge, on timeout, and whenever measurement is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || state == IDLE || edge_p || hit_to) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_inc;
      end
   end

endmodule

module multi_ch_period_meter #(
   parameter int  NUM_CH   = 8,
   parameter int  CNT_W    = 32,
   parameter int  FILT_LEN = 100,
   parameter int  TIMEOUT  = 400000000,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] phase_in,
   output logic [NUM_CH-1:0] ch_active,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [CNT_W-1:0]  out_period,
   output logic              out_timeout,
   output logic              out_overrun
);

   logic [NUM_CH-1:0] cap;
   logic [NUM_CH-1:0] cap_timeout;
   logic [CNT_W-1:0]  cap_period [NUM_CH];

   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] s_timeout;
   logic [NUM_CH-1:0] s_overrun;
   logic [CNT_W-1:0]  s_period [NUM_CH];
   logic [NUM_CH-1:0] drain;

   logic [CH_W-1:0]   rr;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   idx;
   logic              found;
   logic              load;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      period_meter_ch #(
         .CNT_W    (CNT_W),
         .FILT_LEN (FILT_LEN),
         .TIMEOUT  (TIMEOUT)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .phase       (phase_in[g]),
         .active      (ch_active[g]),
         .cap         (cap[g]),
         .cap_period  (cap_period[g]),
         .cap_timeout (cap_timeout[g])
      );
   end

   // Search starts just past the last granted channel so service rotates.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CH_W'((int'(rr) + k) % NUM_CH);
         if (!found && pend[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   assign load = !out_valid || out_ready;

   always_comb begin
      drain = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         drain[i] = load && found && (grant == CH_W'(i));
      end
   end

   // A fresh capture wins over a same-cycle drain; overrun only when an unsent result is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         s_timeout <= '0;
         s_overrun <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            s_period[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
               pend[i]      <= 1'b1;
               s_period[i]  <= cap_period[i];
               s_timeout[i] <= cap_timeout[i];
               s_overrun[i] <= pend[i] && !drain[i];
            end else if (drain[i]) begin
               pend[i]      <= 1'b0;
               s_overrun[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_ch      <= '0;
         out_period  <= '0;
         out_timeout <= 1'b0;
         out_overrun <= 1'b0;
         rr          <= '0;
      end else if (load) begin
         out_valid <= found;
         if (found) begin
            out_ch      <= grant;
            out_period  <= s_period[grant];
            out_timeout <= s_timeout[grant];
            out_overrun <= s_overrun[grant];
            rr          <= grant;
         end
      end
   end

endmodule

// File: tb/tb_multi_ch_period_meter.sv
// Bench for multi_ch_period_meter: directed scenarios plus random traffic, all
// checked cycle by cycle against a timestamp-based behavioural model.

module tb_multi_ch_period_meter;

   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 32;
   localparam int FILT_LEN = 4;
   localparam int TIMEOUT  = 1000;
   localparam int CH_W     = 2;
   localparam int VW       = 1 + CH_W + CNT_W + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [NUM_CH-1:0] phase_in;
   logic [NUM_CH-1:0] ch_active;
   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_ch;
   logic [CNT_W-1:0]  out_period;
   logic              out_timeout;
   logic              out_overrun;

   always #5 clk = ~clk;

   multi_ch_period_meter #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .FILT_LEN (FILT_LEN),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .phase_in    (phase_in),
      .ch_active   (ch_active),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ch      (out_ch),
      .out_period  (out_period),
      .out_timeout (out_timeout),
      .out_overrun (out_overrun)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: raw-sample windows, edge arrival delay, edge timestamps, slots, output.
   logic [FILT_LEN-1:0] m_win  [NUM_CH];
   logic                m_lvl  [NUM_CH];
   logic [2:0]          m_pipe [NUM_CH];
   logic                m_meas [NUM_CH];
   int                  m_last [NUM_CH];
   logic                m_pend [NUM_CH];
   int                  m_per  [NUM_CH];
   logic                m_tmo  [NUM_CH];
   logic                m_ovr  [NUM_CH];
   logic                m_ov;
   int                  m_och;
   int                  m_oper;
   logic                m_otmo;
   logic                m_oovr;
   int                  m_rr;

   task automatic model_tick();
      logic [NUM_CH-1:0] cap;
      logic [NUM_CH-1:0] ctmo;
      int                cper [NUM_CH];
      logic              found;
      logic              flip;
      int                g;
      int                c;
      cyc++;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_win[i] = '0; m_lvl[i] = 1'b0; m_pipe[i] = '0;
            m_meas[i] = 1'b0; m_last[i] = 0;
            m_pend[i] = 1'b0; m_per[i] = 0; m_tmo[i] = 1'b0; m_ovr[i] = 1'b0;
         end
         m_ov = 1'b0; m_och = 0; m_oper = 0; m_otmo = 1'b0; m_oovr = 1'b0; m_rr = 0;
         return;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         cap[i] = 1'b0; ctmo[i] = 1'b0; cper[i] = 0;
         if (!en) begin
            m_meas[i] = 1'b0;
         end else if (m_pipe[i][2]) begin
            if (m_meas[i]) begin
               cap[i] = 1'b1; cper[i] = cyc - m_last[i];
            end
            m_meas[i] = 1'b1; m_last[i] = cyc;
         end else if (m_meas[i] && (cyc - m_last[i] == TIMEOUT)) begin
            cap[i] = 1'b1; ctmo[i] = 1'b1; m_meas[i] = 1'b0;
         end
         m_win[i] = {m_win[i][FILT_LEN-2:0], phase_in[i]};
         flip = (m_win[i] == {FILT_LEN{phase_in[i]}}) && (phase_in[i] != m_lvl[i]);
         if (flip) m_lvl[i] = phase_in[i];
         m_pipe[i] = {m_pipe[i][1:0], flip && phase_in[i]};
      end
      found = 1'b0; g = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         c = (m_rr + k) % NUM_CH;
         if (!found && m_pend[c]) begin found = 1'b1; g = c; end
      end
      if (!(!m_ov || out_ready)) found = 1'b0;
      else begin
         m_ov = found;
         if (found) begin
            m_och = g; m_oper = m_per[g]; m_otmo = m_tmo[g]; m_oovr = m_ovr[g]; m_rr = g;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (cap[i]) begin
            m_ovr[i]  = m_pend[i] && !(found && g == i);
            m_pend[i] = 1'b1; m_per[i] = cper[i]; m_tmo[i] = ctmo[i];
         end else if (found && g == i) begin
            m_pend[i] = 1'b0; m_ovr[i] = 1'b0;
         end
      end
   endtask

   function automatic logic [VW-1:0] m_vec();
      return m_ov ? {1'b1, CH_W'(m_och), CNT_W'(m_oper), m_otmo, m_oovr} : '0;
   endfunction

   function automatic logic [NUM_CH-1:0] m_act();
      logic [NUM_CH-1:0] a;
      for (int i = 0; i < NUM_CH; i++) a[i] = m_meas[i];
      return a;
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return out_valid ? {1'b1, out_ch, out_period, out_timeout, out_overrun} : '0;
   endfunction

   task automatic step();
      @(posedge clk);
      model_tick();
      @(negedge clk);
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1; phase_in = '0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; out_ready = 1'b1; phase_in = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if ({ch_active, out_valid, out_ch, out_period, out_timeout, out_overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_state got %h expected 0", {ch_active, out_valid, out_ch, out_period, out_timeout, out_overrun});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_square();
      int nres = 0;
      apply_reset(2);
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         phase_in = '0;
         phase_in[0] = (i % 200) < 100;
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL square cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
         if (out_valid) begin
            nres++; n_vec++;
            if ({out_ch, out_period, out_timeout, out_overrun} !== {2'd0, 32'd200, 1'b0, 1'b0}) begin
               n_err++;
               $display("FAIL square_result got ch=%0d per=%0d to=%b ov=%b expected ch=0 per=200 to=0 ov=0", out_ch, out_period, out_timeout, out_overrun);
            end
         end
      end
      n_vec++;
      if (nres != 4) begin n_err++; $display("FAIL square_count got %0d expected 4", nres); end
   endtask

   task automatic test_glitch();
      int nres = 0;
      int g0 = 120, g1 = 200, l0 = 1, l1 = 1, m;
      apply_reset(2);
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         m = i % 300;
         if (m == 0) begin
            g0 = $urandom_range(110, 200); l0 = $urandom_range(1, 3);
            g1 = $urandom_range(g0 + 10, 280); l1 = $urandom_range(1, 3);
         end
         phase_in = '0;
         phase_in[1] = (m < 100) || (m >= g0 && m < g0 + l0) || (m >= g1 && m < g1 + l1);
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL glitch cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
         if (out_valid) begin
            nres++; n_vec++;
            if ({out_ch, out_period, out_timeout, out_overrun} !== {2'd1, 32'd300, 1'b0, 1'b0}) begin
               n_err++;
               $display("FAIL glitch_result got ch=%0d per=%0d to=%b ov=%b expected ch=1 per=300", out_ch, out_period, out_timeout, out_overrun);
            end
         end
      end
      n_vec++;
      if (nres != 3) begin n_err++; $display("FAIL glitch_count got %0d expected 3", nres); end
   endtask

   task automatic test_timeout();
      int nres = 0;
      apply_reset(2);
      out_ready = 1'b1;
      for (int i = 0; i < 1850; i++) begin
         phase_in = '0;
         phase_in[2] = (i < 50) || (i >= 1200 && i < 1250) || (i >= 1700 && i < 1750);
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL timeout cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
         if (i == 500 || i == 1100) begin
            n_vec++;
            if (ch_active[2] !== (i == 500)) begin
               n_err++;
               $display("FAIL timeout_active i=%0d got %b expected %b", i, ch_active[2], i == 500);
            end
         end
         if (out_valid) begin
            nres++; n_vec++;
            if ({out_ch, out_period, out_timeout, out_overrun} !==
                ((nres == 1) ? {2'd2, 32'd0, 1'b1, 1'b0} : {2'd2, 32'd500, 1'b0, 1'b0})) begin
               n_err++;
               $display("FAIL timeout_result n=%0d got ch=%0d per=%0d to=%b ov=%b", nres, out_ch, out_period, out_timeout, out_overrun);
            end
         end
      end
      n_vec++;
      if (nres != 2) begin n_err++; $display("FAIL timeout_count got %0d expected 2", nres); end
   endtask

   task automatic test_back_to_back();
      int nres = 0, prev_ch = 0, prev_i = 0;
      apply_reset(2);
      out_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         phase_in = ((i % 50) < 25) ? '1 : '0;
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL b2b cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
         if (out_valid) begin
            n_vec++;
            if ({out_ch, out_period, out_timeout, out_overrun} !== {CH_W'((prev_ch + 1) % NUM_CH), 32'd50, 1'b0, 1'b0}) begin
               n_err++;
               $display("FAIL b2b_result got ch=%0d per=%0d expected ch=%0d per=50", out_ch, out_period, (prev_ch + 1) % NUM_CH);
            end
            if (nres % NUM_CH != 0) begin
               n_vec++;
               if (i != prev_i + 1) begin n_err++; $display("FAIL b2b_gap got %0d expected %0d", i, prev_i + 1); end
            end
            prev_ch = (prev_ch + 1) % NUM_CH; prev_i = i; nres++;
         end
      end
      n_vec++;
      if (nres != 28) begin n_err++; $display("FAIL b2b_count got %0d expected 28", nres); end
   endtask

   task automatic test_stall();
      int t_valid = -1, post = 0;
      logic [CH_W+CNT_W+1:0] held = '0;
      apply_reset(2);
      out_ready = 1'b0;
      for (int i = 0; i < 400; i++) begin
         phase_in = '0;
         phase_in[3] = (i % 50) < 25;
         out_ready = (t_valid >= 0) && (i >= t_valid + 120);
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL stall cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
         if (t_valid < 0) begin
            if (out_valid) begin t_valid = i; held = {out_ch, out_period, out_timeout, out_overrun}; end
         end else if (i < t_valid + 120) begin
            n_vec++;
            if ({out_valid, out_ch, out_period, out_timeout, out_overrun} !== {1'b1, held}) begin
               n_err++;
               $display("FAIL stall_hold i=%0d got %h expected %h", i, {out_valid, out_ch, out_period, out_timeout, out_overrun}, {1'b1, held});
            end
         end else if (out_valid) begin
            post++; n_vec++;
            if ({out_ch, out_period, out_timeout, out_overrun} !== {2'd3, 32'd50, 1'b0, post == 1}) begin
               n_err++;
               $display("FAIL stall_result n=%0d got ch=%0d per=%0d to=%b ov=%b expected ov=%b", post, out_ch, out_period, out_timeout, out_overrun, post == 1);
            end
         end
      end
      n_vec++;
      if (t_valid < 0 || post == 0) begin n_err++; $display("FAIL stall_seen got t_valid=%0d post=%0d expected results", t_valid, post); end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      apply_reset(2);
      out_ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
         phase_in = ((i % 50) < 25) ? '1 : '0;
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL rstmid cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
      end
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %b expected 1", out_valid); end
      rst = 1'b1; phase_in = '0;
      step();
      n_vec++;
      if ({out_valid, ch_active} !== '0) begin n_err++; $display("FAIL rstmid_drop got %h expected 0", {out_valid, ch_active}); end
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         n_vec++;
         if ({ch_active, out_valid} !== '0 || {ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL rstmid_stale cyc=%0d got %h expected 0", cyc, {ch_active, dut_vec()});
         end
      end
   endtask

   task automatic test_random();
      int per [NUM_CH];
      int hi  [NUM_CH];
      int ph  [NUM_CH];
      logic lvl;
      apply_reset(2);
      for (int c = 0; c < NUM_CH; c++) begin
         per[c] = $urandom_range(20, 150); hi[c] = $urandom_range(5, per[c] - 5); ph[c] = $urandom_range(0, 19);
      end
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ph[c]++;
            if (ph[c] >= per[c]) begin
               ph[c] = 0; per[c] = $urandom_range(20, 150); hi[c] = $urandom_range(5, per[c] - 5);
            end
            lvl = ph[c] < hi[c];
            if ($urandom_range(0, 29) == 0) lvl = !lvl;
            phase_in[c] = lvl;
         end
         out_ready = $urandom_range(0, 9) < 7;
         en = $urandom_range(0, 399) != 0;
         step();
         n_vec++;
         if ({ch_active, dut_vec()} !== {m_act(), m_vec()}) begin
            n_err++;
            $display("FAIL random cyc=%0d got %h expected %h", cyc, {ch_active, dut_vec()}, {m_act(), m_vec()});
         end
      end
      en = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; out_ready = 1'b1; phase_in = '0;
      test_reset();
      test_square();
      test_glitch();
      test_timeout();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
